// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// State encodings, access-width codes and the width-to-byte-count helper.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        MC_IDLE   = 3'd0,
        MC_IFETCH = 3'd1,
        MC_DLOAD  = 3'd2,
        MC_DSTORE = 3'd3,
        MC_DONE   = 3'd4
    } mc_state_e;

    localparam logic [1:0] MW_BYTE = 2'b00;
    localparam logic [1:0] MW_HALF = 2'b01;
    localparam logic [1:0] MW_WORD = 2'b10;

    localparam logic        True_v   = 1'b1;
    localparam logic        False_v  = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Code 11 falls through to a full word.
    function automatic logic [2:0] width_bytes(input logic [1:0] width);
        case (width)
            MW_BYTE: return 3'd1;
            MW_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Fixed-priority select between the instruction and data requesters.
// MEMCTRL_DATA_FIRST_EN gives the data port priority; otherwise the instruction port wins.
module mem_ctrl_arb (
    input  logic inst_req,
    input  logic data_req,
    output logic grant_inst_c,
    output logic grant_data_c
);

    always_comb begin
`ifdef MEMCTRL_DATA_FIRST_EN
        grant_data_c = data_req;
        grant_inst_c = inst_req & ~data_req;
`else
        grant_inst_c = inst_req;
        grant_data_c = data_req & ~inst_req;
`endif
    end

endmodule

// File: rtl/mem_ctrl.sv
// Serializes instruction line refills and data loads/stores onto a byte-wide RAM port.
// Requester priority is selected by MEMCTRL_DATA_FIRST_EN (see mem_ctrl_arb).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    ram_inst_re,
    input  logic [31:0]             ram_inst_addr,
    output logic [8*LINE_BYTES-1:0] ram_inst,
    output logic                    ram_inst_busy,
    input  logic                    mem_re,
    input  logic                    mem_we,
    input  logic [31:0]             mem_addr,
    input  logic [1:0]              mem_width,
    input  logic [31:0]             mem_wdata,
    output logic [31:0]             mem_rdata,
    output logic                    mem_busy,
    output logic [ADDR_WIDTH-1:0]   ram_a,
    output logic [7:0]              ram_dout,
    input  logic [7:0]              ram_din,
    output logic                    ram_wr
);

    localparam int unsigned LINE_W = 8 * LINE_BYTES;
    localparam int unsigned CNT_W  = $clog2(LINE_BYTES + 2);
    localparam int unsigned IDX_W  = $clog2(LINE_BYTES);

    mc_state_e             state, state_nxt;
    logic [CNT_W-1:0]      cnt, nbytes, cnt_inc;
    logic [IDX_W-1:0]      byte_idx;
    logic [ADDR_WIDTH-1:0] base, start_a_c;
    logic [31:0]           wdata;
    logic [LINE_W-1:0]     line_buf, assembled_c;
    logic                  wr_q, rdy_q;
    logic [7:0]            din_hold, din_c;
    logic                  grant_inst_c, grant_data_c;
    logic                  accept_c, active_c, capture_c, advance_c, finish_c;
    logic                  unused_addr_c;

    mem_ctrl_arb u_arb (
        .inst_req     (ram_inst_re),
        .data_req     (mem_re | mem_we),
        .grant_inst_c (grant_inst_c),
        .grant_data_c (grant_data_c)
    );

    assign cnt_inc       = cnt + CNT_W'(1);
    assign byte_idx      = IDX_W'(cnt - CNT_W'(1));
    assign start_a_c     = grant_inst_c ? ADDR_WIDTH'({ram_inst_addr[31:IDX_W], IDX_W'(0)})
                                        : ADDR_WIDTH'(mem_addr);
    assign unused_addr_c = ^ram_inst_addr[IDX_W-1:0];
    assign ram_wr        = wr_q & rdy;

    // The RAM keeps running while rdy is low, so the byte in flight at the first
    // stalled edge is parked and consumed on the resume edge instead of ram_din.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q    <= False_v;
            din_hold <= 8'h00;
        end else begin
            rdy_q <= rdy;
            if (rdy_q && !rdy) din_hold <= ram_din;
        end
    end

    assign din_c = rdy_q ? ram_din : din_hold;

    always_comb begin
        assembled_c = line_buf;
        assembled_c[{byte_idx, 3'b000} +: 8] = din_c;
    end

    always_ff @(posedge clk) begin
        if (rst)      state <= MC_IDLE;
        else if (rdy) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MC_IDLE: begin
                if (grant_inst_c)      state_nxt = MC_IFETCH;
                else if (grant_data_c) state_nxt = mem_we ? MC_DSTORE : MC_DLOAD;
            end
            MC_IFETCH, MC_DLOAD, MC_DSTORE: if (finish_c) state_nxt = MC_DONE;
            MC_DONE: state_nxt = MC_IDLE;
            default: state_nxt = MC_IDLE;
        endcase
    end

    // cnt holds (edges since acceptance - 1) while an access is active.
    always_comb begin
        accept_c  = False_v;
        active_c  = False_v;
        capture_c = False_v;
        advance_c = False_v;
        finish_c  = False_v;
        case (state)
            MC_IDLE: accept_c = grant_inst_c | grant_data_c;
            MC_IFETCH, MC_DLOAD: begin
                active_c  = True_v;
                capture_c = (cnt != '0);
                advance_c = (cnt_inc < nbytes);
                finish_c  = (cnt == nbytes);
            end
            MC_DSTORE: begin
                active_c  = True_v;
                advance_c = (cnt_inc < nbytes);
                finish_c  = (cnt_inc == nbytes);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base          <= '0;
            nbytes        <= '0;
            cnt           <= '0;
            wdata         <= ZeroWord;
            line_buf      <= '0;
            ram_inst      <= '0;
            ram_inst_busy <= False_v;
            mem_rdata     <= ZeroWord;
            mem_busy      <= False_v;
            ram_a         <= '0;
            ram_dout      <= 8'h00;
            wr_q          <= False_v;
        end else if (rdy) begin
            if (accept_c) begin
                base          <= start_a_c;
                ram_a         <= start_a_c;
                cnt           <= '0;
                nbytes        <= grant_inst_c ? CNT_W'(LINE_BYTES) : CNT_W'(width_bytes(mem_width));
                wdata         <= mem_wdata;
                ram_dout      <= mem_wdata[7:0];
                wr_q          <= grant_data_c & mem_we;
                line_buf      <= '0;
                ram_inst_busy <= grant_inst_c;
                mem_busy      <= grant_data_c;
            end
            if (active_c) cnt <= cnt_inc;
            if (advance_c) begin
                ram_a    <= base + ADDR_WIDTH'(cnt_inc);
                ram_dout <= wdata[{cnt_inc[1:0], 3'b000} +: 8];
            end
            if (capture_c) line_buf <= assembled_c;
            if (finish_c) begin
                if (state == MC_IFETCH) ram_inst <= assembled_c;
                if (state == MC_DLOAD)  mem_rdata <= assembled_c[31:0];
                ram_inst_busy <= False_v;
                mem_busy      <= False_v;
                wr_q          <= False_v;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl against a free-running byte RAM model.
module tb_mem_ctrl;

    logic         clk = 1'b0;
    logic         rst, rdy;
    logic         ram_inst_re;
    logic [31:0]  ram_inst_addr;
    logic [127:0] ram_inst;
    logic         ram_inst_busy;
    logic         mem_re, mem_we;
    logic [31:0]  mem_addr;
    logic [1:0]   mem_width;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_busy;
    logic [16:0]  ram_a;
    logic [7:0]   ram_dout;
    logic [7:0]   ram_din;
    logic         ram_wr;

`ifdef MEMCTRL_DATA_FIRST_EN
    localparam bit DATA_FIRST = 1'b1;
`else
    localparam bit DATA_FIRST = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(17), .LINE_BYTES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .ram_inst_re   (ram_inst_re),
        .ram_inst_addr (ram_inst_addr),
        .ram_inst      (ram_inst),
        .ram_inst_busy (ram_inst_busy),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_width     (mem_width),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_busy      (mem_busy),
        .ram_a         (ram_a),
        .ram_dout      (ram_dout),
        .ram_din       (ram_din),
        .ram_wr        (ram_wr)
    );

    logic [7:0] ram [0:131071];

    always @(posedge clk) begin
        ram_din <= ram[ram_a];
        if (ram_wr) ram[ram_a] <= ram_dout;
    end

    typedef struct {
        int           kind;      // 0 fetch, 1 load, 2 store
        logic [31:0]  addr;
        logic [1:0]   width;
        logic [31:0]  wdata;
        logic [127:0] exp_data;  // line, load data, or bytes seen on ram_dout
        int           exp_busy;
        logic [16:0]  exp_a0;
        int           nbytes;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_inst"},      ram_inst, 128'h0);
        check({tag, "_ram_inst_busy"}, 128'(ram_inst_busy), 128'h0);
        check({tag, "_mem_rdata"},     128'(mem_rdata), 128'h0);
        check({tag, "_mem_busy"},      128'(mem_busy), 128'h0);
        check({tag, "_ram_a"},         128'(ram_a), 128'h0);
        check({tag, "_ram_dout"},      128'(ram_dout), 128'h0);
        check({tag, "_ram_wr"},        128'(ram_wr), 128'h0);
    endtask

    task automatic drop_requests();
        ram_inst_re = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
    endtask

    // One complete transaction; the request is held one edge past busy falling.
    task automatic run_vec(input vec_t v, input string tag);
        int busy_n, wr_n, bad_a;
        logic [31:0]  sbytes;
        logic [127:0] got;
        logic [1:0]   sel;
        @(negedge clk);
        mem_addr      = v.addr;
        ram_inst_addr = v.addr;
        mem_width     = v.width;
        mem_wdata     = v.wdata;
        ram_inst_re   = (v.kind == 0);
        mem_re        = (v.kind == 1);
        mem_we        = (v.kind == 2);
        @(negedge clk);
        sel    = {ram_inst_busy, mem_busy};
        busy_n = 0;
        wr_n   = 0;
        bad_a  = 0;
        sbytes = '0;
        while ((ram_inst_busy || mem_busy) && busy_n < 40) begin
            if (busy_n < v.nbytes && ram_a !== v.exp_a0 + 17'(busy_n)) bad_a++;
            if (ram_wr) begin
                wr_n++;
                if (busy_n < 4) sbytes[8*busy_n +: 8] = ram_dout;
            end
            busy_n++;
            @(negedge clk);
        end
        case (v.kind)
            0:       got = ram_inst;
            1:       got = 128'(mem_rdata);
            default: got = 128'(sbytes);
        endcase
        check({tag, "_sel"},      128'(sel), 128'(v.kind == 0 ? 2'b10 : 2'b01));
        check({tag, "_busy"},     128'(busy_n), 128'(v.exp_busy));
        check({tag, "_addr_seq"}, 128'(bad_a), 128'h0);
        check({tag, "_wr_cnt"},   128'(wr_n), 128'(v.kind == 2 ? v.nbytes : 0));
        check({tag, "_data"},     got, v.exp_data);
        @(negedge clk);
        drop_requests();
        repeat (3) @(negedge clk);
        check({tag, "_no_rerun"}, 128'({ram_inst_busy, mem_busy}), 128'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int wr_n;
        logic [16:0] a_frz;
        vec_t v;

        for (int a = 0; a < 131072; a++) ram[a] = 8'(a);
        ram[17'h00007] = 8'h9C;
        ram[17'h1FFFE] = 8'h56;
        ram[17'h1FFFF] = 8'h34;
        ram[17'h00000] = 8'h12;

        vecs[0]  = '{0, 32'h0000_0123, 2'b00, 32'h0, 128'h2F2E2D2C_2B2A2928_27262524_23222120, 17, 17'h00120, 16};
        vecs[1]  = '{2, 32'h0000_0104, 2'b10, 32'hDEADBEEF, 128'hDEADBEEF, 4, 17'h00104, 4};
        vecs[2]  = '{1, 32'h0000_0104, 2'b10, 32'h0, 128'hDEADBEEF, 5, 17'h00104, 4};
        vecs[3]  = '{1, 32'h0000_0007, 2'b00, 32'h0, 128'h0000009C, 2, 17'h00007, 1};
        vecs[4]  = '{1, 32'h0001_FFFF, 2'b01, 32'h0, 128'h00001234, 3, 17'h1FFFF, 2};
        vecs[5]  = '{1, 32'h0001_FFFE, 2'b10, 32'h0, 128'h01123456, 5, 17'h1FFFE, 4};
        vecs[6]  = '{0, 32'h0001_FFF7, 2'b00, 32'h0, 128'h3456FDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0, 17, 17'h1FFF0, 16};
        vecs[7]  = '{1, 32'h8000_0104, 2'b11, 32'h0, 128'hDEADBEEF, 5, 17'h00104, 4};
        vecs[8]  = '{2, 32'h0000_0200, 2'b01, 32'h1234A55A, 128'h0000A55A, 2, 17'h00200, 2};
        vecs[9]  = '{1, 32'h0000_0200, 2'b10, 32'h0, 128'h0302A55A, 5, 17'h00200, 4};
        vecs[10] = '{1, 32'h0000_0201, 2'b00, 32'h0, 128'h000000A5, 2, 17'h00201, 1};
        vecs[11] = '{2, 32'h0000_0007, 2'b00, 32'hFFFFFF77, 128'h00000077, 1, 17'h00007, 1};
        vecs[12] = '{1, 32'h0000_0007, 2'b01, 32'h0, 128'h00000877, 3, 17'h00007, 2};

        rst = 1'b1;
        rdy = 1'b1;
        ram_inst_addr = '0;
        mem_addr  = '0;
        mem_width = '0;
        mem_wdata = '0;
        drop_requests();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests: winner first, loser waits out the DONE cycle.
        @(negedge clk);
        ram_inst_re = 1'b1; ram_inst_addr = 32'h0000_0040;
        mem_re = 1'b1; mem_addr = 32'h0000_0201; mem_width = 2'b00;
        @(negedge clk);
        check("arb_inst_busy", 128'(ram_inst_busy), 128'(!DATA_FIRST));
        check("arb_data_busy", 128'(mem_busy), 128'(DATA_FIRST));
        s = 0;
        while ((DATA_FIRST ? mem_busy : ram_inst_busy) && s < 40) begin s++; @(negedge clk); end
        check("arb_loser_wait_end", 128'(DATA_FIRST ? ram_inst_busy : mem_busy), 128'h0);
        @(negedge clk);
        check("arb_loser_wait_done", 128'(DATA_FIRST ? ram_inst_busy : mem_busy), 128'h0);
        if (DATA_FIRST) mem_re = 1'b0; else ram_inst_re = 1'b0;
        @(negedge clk);
        check("arb_loser_accept", 128'(DATA_FIRST ? ram_inst_busy : mem_busy), 128'h1);
        s = 0;
        while ((ram_inst_busy || mem_busy) && s < 40) begin s++; @(negedge clk); end
        check("arb_line", ram_inst, 128'h4F4E4D4C_4B4A4948_47464544_43424140);
        check("arb_byte", 128'(mem_rdata), 128'h000000A5);
        @(negedge clk);
        drop_requests();
        repeat (3) @(negedge clk);

        // rdy low for three edges in the middle of a line fetch.
        ram_inst_re = 1'b1; ram_inst_addr = 32'h0000_0300;
        @(negedge clk);
        s = 0;
        a_frz = '0;
        while ((ram_inst_busy || mem_busy) && s < 40) begin
            if (s == 4) begin rdy = 1'b0; a_frz = ram_a; end
            if (s == 7) begin
                check("stall_ram_a_frozen", 128'(ram_a), 128'(a_frz));
                check("stall_busy_held", 128'(ram_inst_busy), 128'h1);
                rdy = 1'b1;
            end
            s++;
            @(negedge clk);
        end
        check("stall_fetch_busy", 128'(s), 128'd20);
        check("stall_fetch_line", ram_inst, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        @(negedge clk);
        drop_requests();
        repeat (3) @(negedge clk);

        // rdy low in the middle of a word store gates the write strobe.
        mem_we = 1'b1; mem_addr = 32'h0000_0400; mem_width = 2'b10; mem_wdata = 32'h11223344;
        @(negedge clk);
        wr_n = 0;
        for (int i = 0; i < 2; i++) begin
            if (ram_wr) wr_n++;
            @(negedge clk);
        end
        rdy = 1'b0;
        #1;
        check("store_wr_gated", 128'(ram_wr), 128'h0);
        repeat (2) @(negedge clk);
        rdy = 1'b1;
        #1;
        check("store_wr_restored", 128'(ram_wr), 128'h1);
        s = 0;
        while (mem_busy && s < 40) begin
            if (ram_wr) wr_n++;
            s++;
            @(negedge clk);
        end
        check("store_stall_wr_cnt", 128'(wr_n), 128'd4);
        @(negedge clk);
        drop_requests();
        repeat (3) @(negedge clk);
        v = '{1, 32'h0000_0400, 2'b10, 32'h0, 128'h11223344, 5, 17'h00400, 4};
        run_vec(v, "store_stall_readback");

        // Synchronous reset in the middle of a line fetch.
        ram_inst_re = 1'b1; ram_inst_addr = 32'h0000_0500;
        @(negedge clk);
        for (int i = 0; i < 6; i++) @(negedge clk);
        rst = 1'b1;
        drop_requests();
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        v = '{1, 32'h0000_0007, 2'b00, 32'h0, 128'h00000077, 2, 17'h00007, 1};
        run_vec(v, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
